centimos_euros_seq: RTL and testbench

CENTIMOS_EUROS_SEQ -- requirements
Module: centimos_euros_seq

---
 rtl/centimos_euros_seq_if.sv | 16 +
 rtl/centimos_euros_seq.sv | 69 ++++++
 tb/tb_centimos_euros_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/centimos_euros_seq_if.sv
// centimos_euros_seq_if: request/result bundle between a client and the cents-to-euros converter
// Ports: start/centimos (client drives), busy/done/eurosinteiros/eurosfracao/fracao_bcd/overflow (converter drives)
interface centimos_euros_seq_if #(
  parameter int W = 14
) ();
  logic start;
  logic [W-1:0] centimos;
  logic busy;
  logic done;
  logic [W-7:0] eurosinteiros;
  logic [6:0] eurosfracao;
  logic [7:0] fracao_bcd;
  logic overflow;
  modport master(output start, centimos, input busy, done, eurosinteiros, eurosfracao, fracao_bcd, overflow);
  modport slave(input start, centimos, output busy, done, eurosinteiros, eurosfracao, fracao_bcd, overflow);
endinterface

// File: rtl/centimos_euros_seq.sv
// centimos_euros_seq: sequential cents -> whole euros / remaining cents / BCD cents converter
// Ports: clk, reset (sync, active-high), bus (slave side of centimos_euros_seq_if)
module centimos_euros_seq #(
  parameter int W = 14,
  parameter int MAXC = 9999
) (
  input logic clk,
  input logic reset,
  centimos_euros_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] q;
  logic [6:0] rem;
  logic [4:0] cnt;
  logic [7:0] t;
  logic ge, accept, ovf;
  logic [3:0] tens, units;
  // q starts as the dividend and is shifted left one bit per step, filling in quotient bits;
  // the remainder stays below 100, so the 8-bit trial value t never overflows
  always_comb begin
    t = {rem, q[W-1]};
    ge = t >= 8'd100;
    tens = 4'(rem / 7'd10);
    units = 4'(rem % 7'd10);
    accept = state == IDLE && bus.start;
    ovf = bus.centimos > W'(MAXC);
    state_n = state == IDLE ? (bus.start ? (ovf ? DONE : DIV) : IDLE)
            : state == DIV ? (cnt == 5'(W - 1) ? BCD : DIV)
            : state == BCD ? DONE : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
      rem <= '0;
      cnt <= '0;
      bus.overflow <= 1'b0;
      bus.eurosinteiros <= '0;
      bus.eurosfracao <= '0;
      bus.fracao_bcd <= '0;
    end else begin
      if (accept && ovf) begin
        bus.overflow <= 1'b1;
        bus.eurosinteiros <= '0;
        bus.eurosfracao <= '0;
        bus.fracao_bcd <= '0;
      end
      if (accept && !ovf) begin
        bus.overflow <= 1'b0;
        q <= bus.centimos;
        rem <= '0;
        cnt <= '0;
      end
      if (state == DIV) begin
        q <= {q[W-2:0], ge};
        rem <= ge ? 7'(t - 8'd100) : t[6:0];
        cnt <= cnt + 5'd1;
      end
      if (state == BCD) begin
        bus.eurosinteiros <= q[W-7:0];
        bus.eurosfracao <= rem;
        bus.fracao_bcd <= {tens, units};
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_centimos_euros_seq.sv
// tb_centimos_euros_seq: randomized and directed checks of centimos_euros_seq against an arithmetic model
module tb_centimos_euros_seq;
  localparam int W = 14;
  localparam int MAXC = 9999;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  centimos_euros_seq_if #(.W(W)) bus ();
  centimos_euros_seq #(.W(W), .MAXC(MAXC)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  int lat;
  bit got;
  logic [31:0] r_int, r_frac, r_bcd, r_ovf;

  function automatic void model(input int c, output int e_int, output int e_frac, output int e_bcd,
                                output int e_ovf, output int e_lat);
    e_ovf = c > MAXC ? 1 : 0;
    e_int = e_ovf ? 0 : c / 100;
    e_frac = e_ovf ? 0 : c % 100;
    e_bcd = (e_frac / 10) * 16 + e_frac % 10;
    e_lat = e_ovf ? 1 : W + 2;
  endfunction

  task automatic capture();
    r_int = 32'(bus.eurosinteiros);
    r_frac = 32'(bus.eurosfracao);
    r_bcd = 32'(bus.fracao_bcd);
    r_ovf = 32'(bus.overflow);
  endtask

  // one request; while busy, scribble centimos and toggle start to show both are ignored
  task automatic convert(input int c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.centimos = W'(c);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    got = 0;
    while (!got && lat <= 40) begin
      if (bus.done === 1'b1) begin
        got = 1;
        capture();
      end else begin
        bus.centimos = W'($urandom);
        bus.start = 1'($urandom_range(0, 1));
        @(negedge clk);
        lat++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.centimos = '0;
    repeat (3) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b exp 0", bus.overflow); end
    tests++; if (bus.eurosinteiros !== '0) begin fails++; $display("FAIL reset_int got %0d exp 0", bus.eurosinteiros); end
    tests++; if (bus.eurosfracao !== '0) begin fails++; $display("FAIL reset_frac got %0d exp 0", bus.eurosfracao); end
    tests++; if (bus.fracao_bcd !== '0) begin fails++; $display("FAIL reset_bcd got %0h exp 0", bus.fracao_bcd); end
    // reset wins over a simultaneous start
    bus.start = 1'b1;
    bus.centimos = W'(170);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_priority got busy %0b exp 0", bus.busy); end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_priority_after got busy %0b exp 0", bus.busy); end
    // reset clears a pending overflow flag
    convert(10000);
    tests++; if (r_ovf !== 32'd1) begin fails++; $display("FAIL reset_pre_ovf got %0d exp 1", r_ovf); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_clears_ovf got %0b exp 0", bus.overflow); end
  endtask

  task automatic test_vectors();
    int vin[6] = '{170, 0, 9999, 10000, 0, 100};
    int vi[6] = '{1, 0, 99, 0, 0, 1};
    int vf[6] = '{70, 0, 99, 0, 0, 0};
    int vb[6] = '{'h70, 0, 'h99, 0, 0, 0};
    int vo[6] = '{0, 0, 0, 1, 0, 0};
    int vl[6] = '{16, 16, 16, 1, 16, 16};
    for (int i = 0; i < 6; i++) begin
      convert(vin[i]);
      tests++; if (lat !== vl[i]) begin fails++; $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, vl[i]); end
      tests++; if (r_int !== vi[i]) begin fails++; $display("FAIL vec%0d_int got %0d exp %0d", i, r_int, vi[i]); end
      tests++; if (r_frac !== vf[i]) begin fails++; $display("FAIL vec%0d_frac got %0d exp %0d", i, r_frac, vf[i]); end
      tests++; if (r_bcd !== vb[i]) begin fails++; $display("FAIL vec%0d_bcd got %0h exp %0h", i, r_bcd, vb[i]); end
      tests++; if (r_ovf !== vo[i]) begin fails++; $display("FAIL vec%0d_ovf got %0d exp %0d", i, r_ovf, vo[i]); end
      @(negedge clk);
      tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL vec%0d_idle got busy %0b done %0b exp 0 0", i, bus.busy, bus.done); end
    end
  endtask

  task automatic test_random();
    int c, e_int, e_frac, e_bcd, e_ovf, e_lat;
    for (int i = 0; i < 25; i++) begin
      c = $urandom_range(0, 3) == 0 ? int'($urandom_range(MAXC + 1, (1 << W) - 1)) : int'($urandom_range(0, MAXC));
      model(c, e_int, e_frac, e_bcd, e_ovf, e_lat);
      convert(c);
      tests++; if (lat !== e_lat) begin fails++; $display("FAIL rand_latency c=%0d got %0d exp %0d", c, lat, e_lat); end
      tests++; if (r_int !== e_int) begin fails++; $display("FAIL rand_int c=%0d got %0d exp %0d", c, r_int, e_int); end
      tests++; if (r_frac !== e_frac) begin fails++; $display("FAIL rand_frac c=%0d got %0d exp %0d", c, r_frac, e_frac); end
      tests++; if (r_bcd !== e_bcd) begin fails++; $display("FAIL rand_bcd c=%0d got %0h exp %0h", c, r_bcd, e_bcd); end
      tests++; if (r_ovf !== e_ovf) begin fails++; $display("FAIL rand_ovf c=%0d got %0d exp %0d", c, r_ovf, e_ovf); end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int dcyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.centimos = W'(1234);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.start = cyc == 5;
      if (cyc == 5) bus.centimos = W'(5678);
      if (bus.done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin dcyc = cyc; capture(); end
      end
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    tests++; if (dcyc !== 16) begin fails++; $display("FAIL ignore_done_cycle got %0d exp 16", dcyc); end
    tests++; if (r_int !== 32'd12) begin fails++; $display("FAIL ignore_int got %0d exp 12", r_int); end
    tests++; if (r_frac !== 32'd34) begin fails++; $display("FAIL ignore_frac got %0d exp 34", r_frac); end
    tests++; if (r_bcd !== 32'h34) begin fails++; $display("FAIL ignore_bcd got %0h exp 34", r_bcd); end
  endtask

  task automatic test_abort();
    int ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.centimos = W'(905);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (cyc == 7) begin
        tests++; if (bus.eurosfracao !== 7'd34) begin fails++; $display("FAIL abort_hold got %0d exp 34", bus.eurosfracao); end
      end
      if (cyc == 8) reset = 1'b1;
      if (cyc == 9) begin
        reset = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b exp 0", bus.busy); end
        tests++; if (bus.eurosinteiros !== '0 || bus.eurosfracao !== '0 || bus.fracao_bcd !== '0) begin
          fails++; $display("FAIL abort_zero got %0d/%0d/%0h exp 0/0/0", bus.eurosinteiros, bus.eurosfracao, bus.fracao_bcd);
        end
      end
      if (bus.done === 1'b1) ndone++;
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
    convert(905);
    tests++; if (lat !== 16) begin fails++; $display("FAIL abort_retry_latency got %0d exp 16", lat); end
    tests++; if (r_int !== 32'd9 || r_frac !== 32'd5 || r_bcd !== 32'h05) begin
      fails++; $display("FAIL abort_retry got %0d/%0d/%0h exp 9/5/05", r_int, r_frac, r_bcd);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int times[3] = '{0, 0, 0};
    int exp_t[3] = '{16, 33, 50};
    @(negedge clk);
    bus.start = 1'b1;
    bus.centimos = W'(250);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (n < 3) times[n] = cyc;
        n++;
        tests++; if (bus.eurosinteiros !== 8'd2 || bus.eurosfracao !== 7'd50 || bus.fracao_bcd !== 8'h50) begin
          fails++; $display("FAIL b2b_value%0d got %0d/%0d/%0h exp 2/50/50", n, bus.eurosinteiros, bus.eurosfracao, bus.fracao_bcd);
        end
        if (n == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", n); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (times[i] !== exp_t[i]) begin fails++; $display("FAIL b2b_cycle%0d got %0d exp %0d", i, times[i], exp_t[i]); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.centimos = '0;
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
